// File: rtl/cash_fetch_arbiter_pkg.sv
// cash_fetch_arbiter_pkg: shared encodings and defaults for the cash read-port arbiter.
// Rev 1.0
`default_nettype none

package cash_fetch_arbiter_pkg;

  localparam int ADDR_WIDTH_DEF = 16;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int IR_BURST_DEF   = 8;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE     = 3'b001;
  localparam state_t S_IR_BURST = 3'b010;
  localparam state_t S_DATA_RD  = 3'b100;

  localparam logic REQ_IR   = 1'b0;
  localparam logic REQ_DATA = 1'b1;

endpackage

`default_nettype wire

// File: rtl/cash_rr_arbiter.sv
// cash_rr_arbiter: two-requester round-robin grant; block_ir masks the IR requester.
// Rev 1.0
`default_nettype none

module cash_rr_arbiter
  import cash_fetch_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic ir_req,
  input  logic data_req,
  input  logic block_ir,
  output logic gnt_ir,
  output logic gnt_data
);

  logic last_grant;
  logic ir_eligible;

  assign ir_eligible = ir_req & ~block_ir;

  // On a tie the requester that did not win last time gets the port.
  assign gnt_ir   = enable & ir_eligible & (~data_req | (last_grant == REQ_DATA));
  assign gnt_data = enable & data_req & (~ir_eligible | (last_grant == REQ_IR));

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= REQ_DATA;
    end else if (gnt_ir) begin
      last_grant <= REQ_IR;
    end else if (gnt_data) begin
      last_grant <= REQ_DATA;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cash_fetch_arbiter.sv
// cash_fetch_arbiter: shares the cash read port between the IR-block loader and the data loader.
// Rev 1.0
`default_nettype none

module cash_fetch_arbiter
  import cash_fetch_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int IR_BURST   = IR_BURST_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_ir_req,
  input  logic [ADDR_WIDTH-1:0] i_ir_addr,
  output logic                  o_ir_gnt,
  output logic                  o_ir_valid,
  output logic [2:0]            o_ir_index,
  output logic                  o_ir_done,
  input  logic                  i_data_req,
  input  logic [ADDR_WIDTH-1:0] i_data_addr,
  output logic                  o_data_gnt,
  output logic                  o_data_valid,
  input  logic                  i_flush,
  output logic                  o_mem_rd,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic                  i_mem_ready,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int                    BEAT_W    = $clog2(IR_BURST);
  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(IR_BURST - 1);
  localparam logic [ADDR_WIDTH-1:0] BEAT_MASK = ADDR_WIDTH'(IR_BURST - 1);

  state_t                state;
  state_t                state_next;
  logic [BEAT_W-1:0]     beat;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  arb_enable;
  logic                  gnt_ir;
  logic                  gnt_data;
  logic                  beat_last;

  assign arb_enable = (state == S_IDLE) & ~rst;
  assign beat_last  = (beat == LAST_BEAT);
  assign o_ir_gnt   = gnt_ir;
  assign o_data_gnt = gnt_data;

  cash_rr_arbiter u_arb (
    .clk      (clk),
    .rst      (rst),
    .enable   (arb_enable),
    .ir_req   (i_ir_req),
    .data_req (i_data_req),
    .block_ir (i_flush),
    .gnt_ir   (gnt_ir),
    .gnt_data (gnt_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = S_IDLE;
    case (state)
      S_IDLE: begin
        if (gnt_ir) begin
          state_next = S_IR_BURST;
        end else if (gnt_data) begin
          state_next = S_DATA_RD;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_IR_BURST: begin
        if (i_flush || (i_mem_ready && beat_last)) begin
          state_next = S_IDLE;
        end else begin
          state_next = S_IR_BURST;
        end
      end
      S_DATA_RD: state_next = i_mem_ready ? S_IDLE : S_DATA_RD;
      default:   state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_mem_rd   = 1'b0;
    o_mem_addr = addr;
    case (state)
      S_IR_BURST: begin
        o_mem_rd   = 1'b1;
        o_mem_addr = {addr[ADDR_WIDTH-1:BEAT_W], beat};
      end
      S_DATA_RD: o_mem_rd = 1'b1;
      default:   o_mem_rd = 1'b0;
    endcase
  end

  // A ready that coincides with a flush is dropped: no strobe, no rdata update.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr         <= '0;
      beat         <= '0;
      o_rdata      <= '0;
      o_ir_valid   <= 1'b0;
      o_ir_index   <= '0;
      o_ir_done    <= 1'b0;
      o_data_valid <= 1'b0;
    end else begin
      o_ir_valid   <= 1'b0;
      o_ir_done    <= 1'b0;
      o_data_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (gnt_ir) begin
            addr <= i_ir_addr & ~BEAT_MASK;
            beat <= '0;
          end else if (gnt_data) begin
            addr <= i_data_addr;
          end
        end
        S_IR_BURST: begin
          if (i_flush) begin
            beat <= '0;
          end else if (i_mem_ready) begin
            o_rdata    <= i_mem_rdata;
            o_ir_valid <= 1'b1;
            o_ir_index <= 3'(beat);
            o_ir_done  <= beat_last;
            beat       <= beat + 1'b1;
          end
        end
        S_DATA_RD: begin
          if (i_mem_ready) begin
            o_rdata      <= i_mem_rdata;
            o_data_valid <= 1'b1;
          end
        end
        default: beat <= '0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cash_fetch_arbiter.sv
// tb_cash_fetch_arbiter: directed self-checking bench for cash_fetch_arbiter.
// Rev 1.0
`default_nettype none

module tb_cash_fetch_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ir_req;
  logic [15:0] ir_addr;
  logic        ir_gnt;
  logic        ir_valid;
  logic [2:0]  ir_index;
  logic        ir_done;
  logic        data_req;
  logic [15:0] data_addr;
  logic        data_gnt;
  logic        data_valid;
  logic        flush;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic        mem_ready;
  logic [7:0]  mem_rdata;
  logic [7:0]  rdata;
  logic        force_en;
  logic [7:0]  force_val;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Memory model: data is a fixed function of the address unless overridden.
  function automatic logic [7:0] mdat(input logic [15:0] a);
    return a[7:0] + 8'h11;
  endfunction

  assign mem_rdata = force_en ? force_val : mdat(mem_addr);

  cash_fetch_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .i_ir_req     (ir_req),
    .i_ir_addr    (ir_addr),
    .o_ir_gnt     (ir_gnt),
    .o_ir_valid   (ir_valid),
    .o_ir_index   (ir_index),
    .o_ir_done    (ir_done),
    .i_data_req   (data_req),
    .i_data_addr  (data_addr),
    .o_data_gnt   (data_gnt),
    .o_data_valid (data_valid),
    .i_flush      (flush),
    .o_mem_rd     (mem_rd),
    .o_mem_addr   (mem_addr),
    .i_mem_ready  (mem_ready),
    .i_mem_rdata  (mem_rdata),
    .o_rdata      (rdata)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b1; ir_req = 1'b0; ir_addr = '0; data_req = 1'b0; data_addr = '0;
    flush = 1'b0; mem_ready = 1'b1; force_en = 1'b0; force_val = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (ir_gnt !== 1'b0)      begin n_fail++; $display("FAIL reset ir_gnt got %b exp 0", ir_gnt); end
    n_checks++; if (data_gnt !== 1'b0)    begin n_fail++; $display("FAIL reset data_gnt got %b exp 0", data_gnt); end
    n_checks++; if (ir_valid !== 1'b0)    begin n_fail++; $display("FAIL reset ir_valid got %b exp 0", ir_valid); end
    n_checks++; if (ir_index !== 3'd0)    begin n_fail++; $display("FAIL reset ir_index got %0d exp 0", ir_index); end
    n_checks++; if (ir_done !== 1'b0)     begin n_fail++; $display("FAIL reset ir_done got %b exp 0", ir_done); end
    n_checks++; if (data_valid !== 1'b0)  begin n_fail++; $display("FAIL reset data_valid got %b exp 0", data_valid); end
    n_checks++; if (mem_rd !== 1'b0)      begin n_fail++; $display("FAIL reset mem_rd got %b exp 0", mem_rd); end
    n_checks++; if (mem_addr !== 16'h0)   begin n_fail++; $display("FAIL reset mem_addr got %h exp 0000", mem_addr); end
    n_checks++; if (rdata !== 8'h0)       begin n_fail++; $display("FAIL reset rdata got %h exp 00", rdata); end
  endtask

  task automatic test_ir_burst();
    logic [15:0] ea;
    @(posedge clk); #1 ir_req = 1'b1; ir_addr = 16'h1234;
    @(negedge clk);
    n_checks++; if (ir_gnt !== 1'b1) begin n_fail++; $display("FAIL burst ir_gnt got %b exp 1", ir_gnt); end
    for (int k = 0; k <= 9; k++) begin
      @(posedge clk); #1 if (k == 0) ir_req = 1'b0;
      @(negedge clk);
      n_checks++; if (mem_rd !== (k < 8)) begin n_fail++; $display("FAIL burst mem_rd k=%0d got %b exp %b", k, mem_rd, (k < 8)); end
      if (k < 8) begin
        ea = 16'h1230 + 16'(k);
        n_checks++; if (mem_addr !== ea) begin n_fail++; $display("FAIL burst mem_addr k=%0d got %h exp %h", k, mem_addr, ea); end
      end
      n_checks++; if (ir_valid !== (k >= 1 && k <= 8)) begin n_fail++; $display("FAIL burst ir_valid k=%0d got %b", k, ir_valid); end
      if (k >= 1 && k <= 8) begin
        ea = 16'h1230 + 16'(k - 1);
        n_checks++; if (ir_index !== 3'(k - 1)) begin n_fail++; $display("FAIL burst ir_index k=%0d got %0d exp %0d", k, ir_index, k - 1); end
        n_checks++; if (rdata !== mdat(ea)) begin n_fail++; $display("FAIL burst rdata k=%0d got %h exp %h", k, rdata, mdat(ea)); end
      end
      n_checks++; if (ir_done !== (k == 8)) begin n_fail++; $display("FAIL burst ir_done k=%0d got %b exp %b", k, ir_done, (k == 8)); end
      n_checks++; if (ir_gnt !== 1'b0) begin n_fail++; $display("FAIL burst spurious ir_gnt k=%0d", k); end
    end
  endtask

  task automatic test_round_robin();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    ir_req = 1'b1; ir_addr = 16'h2000; data_req = 1'b1; data_addr = 16'h0042;
    @(negedge clk);
    n_checks++; if (ir_gnt !== 1'b1 || data_gnt !== 1'b0) begin n_fail++; $display("FAIL rr first ir_gnt=%b data_gnt=%b exp 1/0", ir_gnt, data_gnt); end
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1 if (k == 1) ir_addr = 16'h300D;
      @(negedge clk);
      n_checks++; if (ir_gnt !== 1'b0 || data_gnt !== 1'b0) begin n_fail++; $display("FAIL rr busy gnt k=%0d ir=%b data=%b exp 0/0", k, ir_gnt, data_gnt); end
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (data_gnt !== 1'b1 || ir_gnt !== 1'b0) begin n_fail++; $display("FAIL rr second data_gnt=%b ir_gnt=%b exp 1/0", data_gnt, ir_gnt); end
    n_checks++; if (ir_done !== 1'b1) begin n_fail++; $display("FAIL rr ir_done got %b exp 1", ir_done); end
    @(posedge clk); #1 data_req = 1'b0;
    @(negedge clk);
    n_checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0042) begin n_fail++; $display("FAIL rr data read rd=%b addr=%h exp 1/0042", mem_rd, mem_addr); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (data_valid !== 1'b1 || rdata !== 8'h53) begin n_fail++; $display("FAIL rr data_valid=%b rdata=%h exp 1/53", data_valid, rdata); end
    n_checks++; if (ir_gnt !== 1'b1) begin n_fail++; $display("FAIL rr third ir_gnt got %b exp 1", ir_gnt); end
    @(posedge clk); #1 ir_req = 1'b0;
    @(negedge clk);
    n_checks++; if (mem_addr !== 16'h3008) begin n_fail++; $display("FAIL rr aligned base got %h exp 3008", mem_addr); end
    repeat (8) @(posedge clk);
    @(negedge clk);
    n_checks++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL rr drain mem_rd got %b exp 0", mem_rd); end
  endtask

  task automatic test_data_wait();
    @(posedge clk); #1 mem_ready = 1'b0; data_req = 1'b1; data_addr = 16'h00A5;
    @(negedge clk);
    n_checks++; if (data_gnt !== 1'b1 || ir_gnt !== 1'b0) begin n_fail++; $display("FAIL wait data_gnt=%b ir_gnt=%b exp 1/0", data_gnt, ir_gnt); end
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1 if (k == 1) data_req = 1'b0;
      @(negedge clk);
      n_checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h00A5) begin n_fail++; $display("FAIL wait hold k=%0d rd=%b addr=%h exp 1/00a5", k, mem_rd, mem_addr); end
      n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL wait early data_valid k=%0d", k); end
    end
    @(posedge clk); #1 mem_ready = 1'b1; force_en = 1'b1; force_val = 8'h5C;
    @(negedge clk);
    n_checks++; if (mem_addr !== 16'h00A5) begin n_fail++; $display("FAIL wait ready addr got %h exp 00a5", mem_addr); end
    @(posedge clk); #1 force_en = 1'b0;
    @(negedge clk);
    n_checks++; if (data_valid !== 1'b1 || rdata !== 8'h5C || mem_rd !== 1'b0) begin n_fail++; $display("FAIL wait result valid=%b rdata=%h rd=%b exp 1/5c/0", data_valid, rdata, mem_rd); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (data_valid !== 1'b0 || rdata !== 8'h5C) begin n_fail++; $display("FAIL wait after valid=%b rdata=%h exp 0/5c", data_valid, rdata); end
  endtask

  task automatic test_flush();
    @(posedge clk); #1 ir_req = 1'b1; ir_addr = 16'h4440;
    @(negedge clk);
    n_checks++; if (ir_gnt !== 1'b1) begin n_fail++; $display("FAIL flush ir_gnt got %b exp 1", ir_gnt); end
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin ir_req = 1'b0; data_req = 1'b1; data_addr = 16'h0077; end
      if (k == 4) flush = 1'b1;
      if (k == 5) flush = 1'b0;
      @(negedge clk);
      if (k >= 2 && k <= 4) begin
        n_checks++; if (ir_valid !== 1'b1 || ir_index !== 3'(k - 2)) begin n_fail++; $display("FAIL flush beat k=%0d valid=%b index=%0d exp 1/%0d", k, ir_valid, ir_index, k - 2); end
      end
      if (k <= 4) begin
        n_checks++; if (data_gnt !== 1'b0) begin n_fail++; $display("FAIL flush early data_gnt k=%0d", k); end
      end
    end
    n_checks++; if (ir_valid !== 1'b0 || ir_done !== 1'b0) begin n_fail++; $display("FAIL flush discard valid=%b done=%b exp 0/0", ir_valid, ir_done); end
    n_checks++; if (mem_rd !== 1'b0 || data_gnt !== 1'b1) begin n_fail++; $display("FAIL flush idle rd=%b data_gnt=%b exp 0/1", mem_rd, data_gnt); end
    n_checks++; if (rdata !== 8'h53) begin n_fail++; $display("FAIL flush rdata kept got %h exp 53", rdata); end
    @(posedge clk); #1 data_req = 1'b0;
    @(negedge clk);
    n_checks++; if (mem_addr !== 16'h0077) begin n_fail++; $display("FAIL flush data addr got %h exp 0077", mem_addr); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (data_valid !== 1'b1 || rdata !== 8'h88) begin n_fail++; $display("FAIL flush data valid=%b rdata=%h exp 1/88", data_valid, rdata); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1 ir_req = 1'b1; ir_addr = 16'h5550;
    @(negedge clk);
    n_checks++; if (ir_gnt !== 1'b1) begin n_fail++; $display("FAIL rstmid ir_gnt got %b exp 1", ir_gnt); end
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k == 1) ir_req = 1'b0;
      if (k == 6) rst = 1'b1;
      @(negedge clk);
    end
    n_checks++; if (mem_addr !== 16'h5555) begin n_fail++; $display("FAIL rstmid beat5 addr got %h exp 5555", mem_addr); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (ir_valid !== 1'b0 || ir_index !== 3'd0 || ir_done !== 1'b0) begin n_fail++; $display("FAIL rstmid ir outs valid=%b index=%0d done=%b exp 0/0/0", ir_valid, ir_index, ir_done); end
    n_checks++; if (mem_rd !== 1'b0 || mem_addr !== 16'h0 || rdata !== 8'h0 || data_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid rd=%b addr=%h rdata=%h dv=%b exp 0/0000/00/0", mem_rd, mem_addr, rdata, data_valid); end
    @(posedge clk); #1 ir_req = 1'b1; ir_addr = 16'h6668;
    @(negedge clk);
    n_checks++; if (ir_gnt !== 1'b1) begin n_fail++; $display("FAIL rstmid regrant ir_gnt got %b exp 1", ir_gnt); end
    @(posedge clk); #1 ir_req = 1'b0;
    @(negedge clk);
    n_checks++; if (mem_addr !== 16'h6668) begin n_fail++; $display("FAIL rstmid new base got %h exp 6668", mem_addr); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (ir_valid !== 1'b1 || ir_index !== 3'd0 || rdata !== 8'h79) begin n_fail++; $display("FAIL rstmid first beat valid=%b index=%0d rdata=%h exp 1/0/79", ir_valid, ir_index, rdata); end
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_flush_idle();
    @(posedge clk); #1 flush = 1'b1; ir_req = 1'b1; ir_addr = 16'h7000; data_req = 1'b1; data_addr = 16'h0011;
    @(negedge clk);
    n_checks++; if (data_gnt !== 1'b1 || ir_gnt !== 1'b0) begin n_fail++; $display("FAIL fidle data_gnt=%b ir_gnt=%b exp 1/0", data_gnt, ir_gnt); end
    @(posedge clk); #1 data_req = 1'b0;
    @(negedge clk);
    n_checks++; if (ir_gnt !== 1'b0) begin n_fail++; $display("FAIL fidle busy ir_gnt got %b exp 0", ir_gnt); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (data_valid !== 1'b1 || rdata !== 8'h22) begin n_fail++; $display("FAIL fidle data valid=%b rdata=%h exp 1/22", data_valid, rdata); end
    n_checks++; if (ir_gnt !== 1'b0) begin n_fail++; $display("FAIL fidle blocked ir_gnt got %b exp 0", ir_gnt); end
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    n_checks++; if (ir_gnt !== 1'b1) begin n_fail++; $display("FAIL fidle release ir_gnt got %b exp 1", ir_gnt); end
    @(posedge clk); #1 ir_req = 1'b0;
    @(negedge clk);
    n_checks++; if (mem_addr !== 16'h7000 || mem_rd !== 1'b1) begin n_fail++; $display("FAIL fidle ir addr=%h rd=%b exp 7000/1", mem_addr, mem_rd); end
    repeat (9) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_ir_burst();
    test_round_robin();
    test_data_wait();
    test_flush();
    test_reset_mid();
    test_flush_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
